// File: rtl/miner_work_loader_pkg.sv
// miner_work_loader_pkg: register map, CTRL/STATUS bit positions, loader FSM states
package miner_work_loader_pkg;
   localparam logic [4:0] ADDR_MID_BASE  = 5'd0;
   localparam logic [4:0] ADDR_DATA_BASE = 5'd8;
   localparam logic [4:0] ADDR_NONCE     = 5'd24;
   localparam logic [4:0] ADDR_CTRL      = 5'd25;
   localparam logic [4:0] ADDR_STATUS    = 5'd26;
   localparam logic [4:0] ADDR_GOLDEN    = 5'd27;
   localparam int CTRL_COMMIT    = 0;
   localparam int CTRL_CLR_OVF   = 1;
   localparam int CTRL_IRQ_EN    = 2;
   localparam int STAT_NOT_EMPTY = 0;
   localparam int STAT_OVF       = 1;
   localparam int STAT_CNT       = 2;
   localparam int STAT_RUNNING   = 8;
   localparam int STAT_STAGED    = 9;
   localparam logic [31:0] GOLDEN_EMPTY = 32'hFFFF_FFFF;
   typedef enum logic [1:0] {S_IDLE, S_STAGED, S_LOAD, S_RUNNING} state_t;
   function automatic logic [31:0] status_word(input logic not_empty, input logic ovf,
                                               input logic [4:0] cnt, input logic running,
                                               input logic staged);
      logic [31:0] s;
      s = '0;
      s[STAT_NOT_EMPTY] = not_empty;
      s[STAT_OVF] = ovf;
      s[STAT_CNT +: 5] = cnt;
      s[STAT_RUNNING] = running;
      s[STAT_STAGED] = staged;
      return s;
   endfunction
endpackage

// File: rtl/miner_work_loader_fifo.sv
// miner_work_loader_fifo: golden-nonce FIFO; drops pushes when full unless a pop frees a slot
//  clk, reset_n : clock, asynchronous active-low reset
//  push, wdata  : enqueue request and data
//  pop          : dequeue request (ignored when empty)
//  rdata        : head entry (valid when !empty)
//  empty, count : occupancy; drop: push rejected this cycle
module miner_work_loader_fifo #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        push,
   input  logic [31:0] wdata,
   input  logic        pop,
   output logic [31:0] rdata,
   output logic        empty,
   output logic        drop,
   output logic [4:0]  count
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   logic [31:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic full, do_push, do_pop;
   assign full = count == 5'(DEPTH);
   assign empty = count == 5'd0;
   assign do_pop = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign drop = push & ~do_push;
   assign rdata = mem[rp];
   always_ff @(posedge clk)
      if (do_push) mem[wp] <= wdata;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         wp <= '0;
         rp <= '0;
         count <= '0;
      end else begin
         wp <= do_push ? wp + AW'(1) : wp;
         rp <= do_pop ? rp + AW'(1) : rp;
         count <= count + 5'(do_push) - 5'(do_pop);
      end
endmodule

// File: rtl/miner_work_loader.sv
// miner_work_loader: Avalon-MM work staging for the miner plus golden-nonce readback FIFO
//  clk, reset_n                          : clock, asynchronous active-low reset
//  chipselect/address/write/writedata    : Avalon slave write side
//  read/readdata                         : Avalon slave read side, registered, latency 1
//  irq                                   : irq_en & FIFO not empty
//  midstate_buf/data_buf/nonce_start     : active work to the miner
//  newinput                              : one-cycle strobe when active work updates
//  golden_nonce/golden_nonce_ticket      : miner hit report
module miner_work_loader
   import miner_work_loader_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         chipselect,
   input  logic [4:0]   address,
   input  logic         write,
   input  logic [31:0]  writedata,
   input  logic         read,
   output logic [31:0]  readdata,
   output logic         irq,
   output logic [255:0] midstate_buf,
   output logic [511:0] data_buf,
   output logic [31:0]  nonce_start,
   output logic         newinput,
   input  logic [31:0]  golden_nonce,
   input  logic         golden_nonce_ticket
);
   state_t state, state_nx;
   logic [31:0] shadow [25];
   logic [31:0] rd_mux, fifo_head;
   logic [4:0] fifo_count;
   logic wr_en, rd_en, shadow_wr, ctrl_wr, commit, pop, push;
   logic ticket_q, irq_en, overflow, fifo_empty, fifo_drop;
   assign wr_en = chipselect & write;
   assign rd_en = chipselect & read;
   assign shadow_wr = wr_en & (address <= ADDR_NONCE);
   assign ctrl_wr = wr_en & (address == ADDR_CTRL);
   assign commit = ctrl_wr & writedata[CTRL_COMMIT];
   assign pop = rd_en & (address == ADDR_GOLDEN);
   // the miner holds the ticket for several cycles; only its rising edge is a new hit
   assign push = golden_nonce_ticket & ~ticket_q;
   assign newinput = state == S_LOAD;
   assign irq = irq_en & ~fifo_empty;
   always_comb
      state_nx = commit ? S_LOAD : shadow_wr ? S_STAGED : (state == S_LOAD) ? S_RUNNING : state;
   always_comb begin
      rd_mux = '0;
      if (address <= ADDR_NONCE) rd_mux = shadow[address];
      else if (address == ADDR_CTRL) rd_mux[CTRL_IRQ_EN] = irq_en;
      else if (address == ADDR_STATUS)
         rd_mux = status_word(~fifo_empty, overflow, fifo_count, state == S_RUNNING, state == S_STAGED);
      else if (address == ADDR_GOLDEN) rd_mux = fifo_empty ? GOLDEN_EMPTY : fifo_head;
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) for (int i = 0; i < 25; i++) shadow[i] <= '0;
      else if (shadow_wr) shadow[address] <= writedata;
   // active work is copied on the commit edge so it changes together with the LOAD strobe
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         midstate_buf <= '0;
         data_buf <= '0;
         nonce_start <= '0;
      end else if (commit) begin
         for (int i = 0; i < 8; i++) midstate_buf[32*i +: 32] <= shadow[ADDR_MID_BASE + 5'(i)];
         for (int i = 0; i < 16; i++) data_buf[32*i +: 32] <= shadow[ADDR_DATA_BASE + 5'(i)];
         nonce_start <= shadow[ADDR_NONCE];
      end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state <= S_IDLE;
         ticket_q <= 1'b0;
         irq_en <= 1'b0;
         overflow <= 1'b0;
         readdata <= '0;
      end else begin
         state <= state_nx;
         ticket_q <= golden_nonce_ticket;
         irq_en <= ctrl_wr ? writedata[CTRL_IRQ_EN] : irq_en;
         overflow <= (overflow & ~(ctrl_wr & writedata[CTRL_CLR_OVF])) | fifo_drop;
         readdata <= rd_en ? rd_mux : readdata;
      end
   miner_work_loader_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .wdata   (golden_nonce),
      .pop     (pop),
      .rdata   (fifo_head),
      .empty   (fifo_empty),
      .drop    (fifo_drop),
      .count   (fifo_count)
   );
endmodule

// File: tb/tb_miner_work_loader.sv
// tb_miner_work_loader: randomized bus/ticket stimulus against a queue-based reference model
module tb_miner_work_loader;
   localparam int DEPTH = 4;
   localparam logic [4:0] A_NONCE = 5'd24;
   localparam logic [4:0] A_CTRL = 5'd25;
   localparam logic [4:0] A_STATUS = 5'd26;
   localparam logic [4:0] A_GOLDEN = 5'd27;
   localparam logic [255:0] MID = 256'h228ea4732a3c9ba860c009cda7252b9161a5e75ec8c582a5f106abb3af41f790;
   localparam logic [511:0] DATA = {32'h00000280, 352'h0, 32'h80000000, 96'h2194261a9395e64dbed17115};
   logic clk = 1'b0, reset_n = 1'b0;
   logic chipselect = 1'b0, write = 1'b0, read = 1'b0;
   logic [4:0] address = '0;
   logic [31:0] writedata = '0, golden_nonce = '0;
   logic golden_nonce_ticket = 1'b0;
   logic [31:0] readdata, nonce_start;
   logic [255:0] midstate_buf;
   logic [511:0] data_buf;
   logic irq, newinput;
   always #5 clk = ~clk;
   miner_work_loader #(.FIFO_DEPTH(DEPTH)) dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .chipselect          (chipselect),
      .address             (address),
      .write               (write),
      .writedata           (writedata),
      .read                (read),
      .readdata            (readdata),
      .irq                 (irq),
      .midstate_buf        (midstate_buf),
      .data_buf            (data_buf),
      .nonce_start         (nonce_start),
      .newinput            (newinput),
      .golden_nonce        (golden_nonce),
      .golden_nonce_ticket (golden_nonce_ticket)
   );
   int vectors = 0, miscompares = 0, commits = 0, pulses = 0;
   logic [31:0] m_shadow [25];
   logic [255:0] m_mid;
   logic [511:0] m_data;
   logic [31:0] m_nonce;
   logic m_irq_en, m_ovf, m_running, m_staged, m_prev_tk, m_ni;
   logic [31:0] m_fifo [$];
   logic [31:0] exp_q [$];
   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask
   task automatic model_reset();
      for (int i = 0; i < 25; i++) m_shadow[i] = '0;
      m_mid = '0;
      m_data = '0;
      m_nonce = '0;
      m_irq_en = 1'b0;
      m_ovf = 1'b0;
      m_running = 1'b0;
      m_staged = 1'b0;
      m_prev_tk = 1'b0;
      m_ni = 1'b0;
      m_fifo.delete();
   endtask
   function automatic logic [31:0] model_read(input logic [4:0] a);
      if (a <= A_NONCE) return m_shadow[a];
      if (a == A_CTRL) return {29'b0, m_irq_en, 2'b0};
      if (a == A_STATUS)
         return {22'b0, m_staged, m_running, 1'b0, 5'(m_fifo.size()), m_ovf, m_fifo.size() != 0};
      if (a == A_GOLDEN) return (m_fifo.size() != 0) ? m_fifo[0] : 32'hFFFF_FFFF;
      return 32'h0;
   endfunction
   // one bus cycle: check outputs left by the previous cycle, then drive and model this one
   task automatic step(input logic cs, input logic w, input logic r, input logic [4:0] a,
                       input logic [31:0] d, input logic tk, input logic [31:0] gn);
      @(negedge clk);
      check("newinput", newinput, m_ni);
      check("irq", irq, m_irq_en & (m_fifo.size() != 0));
      check("nonce_start", nonce_start, m_nonce);
      check("midstate_buf", midstate_buf, m_mid);
      check("data_buf", data_buf, m_data);
      chipselect = cs;
      write = w;
      read = r;
      address = a;
      writedata = d;
      golden_nonce_ticket = tk;
      golden_nonce = gn;
      m_ni = 1'b0;
      if (cs && r) begin
         exp_q.push_back(model_read(a));
         if (a == A_GOLDEN && m_fifo.size() != 0) void'(m_fifo.pop_front());
      end
      if (cs && w) begin
         if (a <= A_NONCE) begin
            m_shadow[a] = d;
            m_staged = 1'b1;
            m_running = 1'b0;
         end else if (a == A_CTRL) begin
            m_irq_en = d[2];
            if (d[1]) m_ovf = 1'b0;
            if (d[0]) begin
               m_staged = 1'b0;
               m_running = 1'b1;
               m_ni = 1'b1;
               commits++;
               for (int i = 0; i < 8; i++) m_mid[32*i +: 32] = m_shadow[i];
               for (int i = 0; i < 16; i++) m_data[32*i +: 32] = m_shadow[8+i];
               m_nonce = m_shadow[24];
            end
         end
      end
      if (tk && !m_prev_tk) begin
         if (m_fifo.size() < DEPTH) m_fifo.push_back(gn);
         else m_ovf = 1'b1;
      end
      m_prev_tk = tk;
   endtask
   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, golden_nonce_ticket, golden_nonce);
   endtask
   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      step(1'b1, 1'b1, 1'b0, a, d, golden_nonce_ticket, golden_nonce);
      if (a == A_CTRL && d[0]) idle();
   endtask
   task automatic rd(input logic [4:0] a);
      step(1'b1, 1'b0, 1'b1, a, 32'd0, golden_nonce_ticket, golden_nonce);
   endtask
   task automatic tick(input logic tk, input logic [31:0] gn);
      step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, tk, gn);
   endtask
   always @(posedge clk) if (newinput) pulses++;
   logic rd_q = 1'b0;
   logic [31:0] last_rd = '0;
   always @(posedge clk) rd_q <= chipselect & read;
   always @(negedge clk or negedge reset_n)
      if (!reset_n) last_rd = '0;
      else if (rd_q) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL readdata: got %0h, expected no read response", readdata);
         end else begin
            last_rd = exp_q.pop_front();
            check("readdata", readdata, last_rd);
         end
      end else check("readdata_hold", readdata, last_rd);
   initial begin
      int p0;
      model_reset();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      rd(A_STATUS);
      idle();
      for (int i = 0; i < 8; i++) wr(5'(i), MID[32*i +: 32]);
      for (int i = 0; i < 16; i++) wr(5'(8 + i), DATA[32*i +: 32]);
      wr(A_NONCE, 32'h0e33347a);
      rd(A_STATUS);
      p0 = pulses;
      wr(A_CTRL, 32'h5);
      check("load_midstate", midstate_buf, MID);
      check("load_data", data_buf, DATA);
      check("load_nonce", nonce_start, 32'h0e33347a);
      idle();
      idle();
      check("load_pulse_count", pulses, p0 + 1);
      rd(A_STATUS);
      rd(5'd3);
      wr(A_NONCE, 32'h0);
      idle();
      check("restage_nonce_held", nonce_start, 32'h0e33347a);
      rd(A_STATUS);
      wr(A_CTRL, 32'h5);
      check("restage_nonce", nonce_start, 32'h0);
      idle();
      rd(A_STATUS);
      wr(A_CTRL, 32'h1);
      #2 reset_n = 1'b0;
      #1;
      check("rst_newinput", newinput, 1'b0);
      check("rst_midstate", midstate_buf, 256'h0);
      check("rst_data", data_buf, 512'h0);
      check("rst_nonce", nonce_start, 32'h0);
      check("rst_readdata", readdata, 32'h0);
      check("rst_irq", irq, 1'b0);
      commits--;
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      rd(A_STATUS);
      rd(A_NONCE);
      wr(A_CTRL, 32'h4);
      tick(1'b1, 32'h0e33337a);
      idle();
      idle();
      tick(1'b0, 32'h0e33337a);
      check("capture_irq", irq, 1'b1);
      rd(A_STATUS);
      rd(A_GOLDEN);
      rd(A_GOLDEN);
      idle();
      check("drained_irq", irq, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick(1'b1, $urandom());
         tick(1'b0, golden_nonce);
      end
      rd(A_STATUS);
      for (int i = 0; i < 4; i++) rd(A_GOLDEN);
      rd(A_STATUS);
      wr(A_CTRL, 32'h6);
      rd(A_STATUS);
      for (int i = 0; i < 4; i++) begin
         tick(1'b1, $urandom());
         tick(1'b0, golden_nonce);
      end
      step(1'b1, 1'b0, 1'b1, A_GOLDEN, 32'd0, 1'b1, $urandom());
      tick(1'b0, golden_nonce);
      rd(A_STATUS);
      for (int i = 0; i < 4; i++) rd(A_GOLDEN);
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 7))
            0: wr(5'($urandom_range(0, 24)), $urandom());
            1: rd(5'($urandom_range(0, 31)));
            2: wr(A_CTRL, $urandom());
            3: tick(1'($urandom_range(0, 1)), $urandom());
            4: rd(A_GOLDEN);
            5: wr(5'($urandom_range(26, 31)), $urandom());
            6: step(1'b0, 1'($urandom_range(0, 1)), 1'b1, 5'($urandom_range(0, 31)), $urandom(),
                    golden_nonce_ticket, golden_nonce);
            default: idle();
         endcase
      end
      repeat (3) idle();
      check("exp_q_drained", exp_q.size(), 0);
      check("pulse_count", pulses, commits);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
